// File: rtl/bcd_key_arbiter.sv
// Round-robin arbiter sharing one BCD encoder between nine key requesters.
// Rising key edges become pending requests; encoder results are queued in a small FIFO.
module bcd_key_arbiter #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         test_clk,
  input  logic                         rstN,
  input  logic [9:1]                   key_req,
  output logic [9:1]                   enc_decimal,
  input  logic [3:0]                   enc_bcd,
  output logic [3:0]                   out_bcd,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overrun,
  output logic                         enc_err,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StDrive, StCapture} state_e;

  state_e          state_q;
  logic [9:1]      pending_q, key_prev_q, enc_q;
  logic [3:0]      rr_ptr_q, grant_q;
  logic            overrun_q, enc_err_q;

  logic [3:0]      fifo_mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic [3:0]      last_q;

  logic [9:1]      rise, clr, pick_onehot;
  logic [3:0]      pick, idx;
  logic            found, push, pop;

  assign rise = key_req & ~key_prev_q;
  // enc_q still holds the granted one-hot while in CAPTURE
  assign clr  = (state_q == StCapture) ? enc_q : '0;
  assign push = (state_q == StCapture);
  assign pop  = out_valid && out_ready;

  // Round-robin search starting at rr_ptr_q, ascending, wrapping 9 -> 1
  always_comb begin
    found       = 1'b0;
    pick        = 4'd0;
    pick_onehot = '0;
    idx         = 4'd0;
    for (int i = 0; i < 9; i++) begin
      idx = 4'((int'(rr_ptr_q) + i - 1) % 9 + 1);
      if (!found && pending_q[idx]) begin
        found            = 1'b1;
        pick             = idx;
        pick_onehot[idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge test_clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= StIdle;
      pending_q  <= '0;
      key_prev_q <= '0;
      enc_q      <= '0;
      rr_ptr_q   <= 4'd1;
      grant_q    <= 4'd0;
      overrun_q  <= 1'b0;
      enc_err_q  <= 1'b0;
    end else begin
      key_prev_q <= key_req;
      // A new rise on the key being cleared re-arms it rather than counting as overrun
      pending_q  <= (pending_q & ~clr) | rise;
      overrun_q  <= |(rise & pending_q & ~clr);
      enc_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (found && (count_q < CntW'(FIFO_DEPTH))) begin
            grant_q  <= pick;
            enc_q    <= pick_onehot;
            rr_ptr_q <= (pick == 4'd9) ? 4'd1 : pick + 4'd1;
            state_q  <= StDrive;
          end
        end
        StDrive: state_q <= StCapture;
        StCapture: begin
          enc_err_q <= (enc_bcd != grant_q);
          enc_q     <= '0;
          state_q   <= StIdle;
        end
        default: begin
          enc_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge test_clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 4'd0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= enc_bcd;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        last_q   <= fifo_mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign out_valid   = (count_q != '0);
  // Head when non-empty, otherwise the last value handed downstream
  assign out_bcd     = out_valid ? fifo_mem_q[rd_ptr_q] : last_q;
  assign fifo_count  = count_q;
  assign enc_decimal = enc_q;
  assign overrun     = overrun_q;
  assign enc_err     = enc_err_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_key_arbiter.sv
// Directed bench for bcd_key_arbiter: expected results queued by stimulus,
// popped and compared by a monitor whenever the output handshake completes.
module tb_bcd_key_arbiter;

  logic       test_clk = 1'b0;
  logic       rstN;
  logic [9:1] key_req;
  logic [9:1] enc_decimal;
  logic [3:0] enc_bcd;
  logic [3:0] out_bcd;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       enc_err;
  logic       busy;
  logic [2:0] fifo_count;

  logic       force_en;
  logic [3:0] force_val;

  int         checks = 0;
  int         errors = 0;
  int         ovr_cnt = 0;
  int         err_cnt = 0;
  int         ovr_base, err_base;
  logic [3:0] exp_q[$];

  always #5 test_clk = ~test_clk;

  function automatic logic [3:0] enc_model(input logic [9:1] d);
    enc_model = 4'd0;
    for (int k = 1; k <= 9; k++) if (d[k]) enc_model = 4'(k);
  endfunction

  assign enc_bcd = force_en ? force_val : enc_model(enc_decimal);

  bcd_key_arbiter #(.FIFO_DEPTH(4)) dut (
    .test_clk    (test_clk),
    .rstN        (rstN),
    .key_req     (key_req),
    .enc_decimal (enc_decimal),
    .enc_bcd     (enc_bcd),
    .out_bcd     (out_bcd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overrun     (overrun),
    .enc_err     (enc_err),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge test_clk);
    #1;
  endtask

  // Monitor: invariants, pulse counters and scoreboard pops
  always @(negedge test_clk) begin
    if (rstN === 1'b1) begin
      chk("onehot0_enc", 32'($onehot0(enc_decimal)), 32'd1);
      chk("busy_vs_enc", 32'(busy), 32'(enc_decimal != '0));
      if (overrun) ovr_cnt++;
      if (enc_err) err_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 32'(out_bcd), 32'hFFFF);
        end else begin
          chk("scoreboard_bcd", 32'(out_bcd), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rstN = 1'b0; key_req = '0; out_ready = 1'b0; force_en = 1'b0; force_val = 4'd0;
    cyc(2);
    chk("rst_enc", 32'(enc_decimal), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(out_bcd), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_pulses", 32'({overrun, enc_err}), 32'd0);
    rstN = 1'b1;
    cyc(1);

    // Simultaneous keys 2,5,9 from rr_ptr=1
    key_req = 9'b100010010;
    cyc(10);
    chk("sim_count", 32'(fifo_count), 32'd3);
    chk("sim_head", 32'(out_bcd), 32'd2);
    chk("sim_idle", 32'(busy), 32'd0);
    exp_q.push_back(4'd2); exp_q.push_back(4'd5); exp_q.push_back(4'd9);
    out_ready = 1'b1;
    cyc(4);
    chk("sim_drained", 32'(fifo_count), 32'd0);
    key_req = '0; out_ready = 1'b0;
    cyc(2);

    // Single key 3
    key_req[3] = 1'b1;
    cyc(1);
    chk("single_e0_enc", 32'(enc_decimal), 32'd0);
    cyc(1);
    chk("single_e1_enc", 32'(enc_decimal), 32'h004);
    chk("single_e1_busy", 32'(busy), 32'd1);
    cyc(1);
    chk("single_e2_enc", 32'(enc_decimal), 32'h004);
    cyc(1);
    chk("single_e3_valid", 32'(out_valid), 32'd1);
    chk("single_e3_bcd", 32'(out_bcd), 32'd3);
    chk("single_e3_count", 32'(fifo_count), 32'd1);
    chk("single_e3_enc", 32'(enc_decimal), 32'd0);
    exp_q.push_back(4'd3);
    out_ready = 1'b1;
    cyc(1);
    chk("single_pop_count", 32'(fifo_count), 32'd0);
    chk("single_hold_bcd", 32'(out_bcd), 32'd3);
    out_ready = 1'b0; key_req = '0;
    cyc(2);

    // FIFO full: keys 1,2,5,6,8,9 with rr_ptr=4
    ovr_base = ovr_cnt;
    key_req = 9'b110110011;
    cyc(20);
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_busy", 32'(busy), 32'd0);
    chk("full_enc", 32'(enc_decimal), 32'd0);
    chk("full_head", 32'(out_bcd), 32'd5);
    exp_q.push_back(4'd5); exp_q.push_back(4'd6); exp_q.push_back(4'd8);
    exp_q.push_back(4'd9); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    out_ready = 1'b1;
    cyc(30);
    chk("full_drained", 32'(fifo_count), 32'd0);
    chk("full_no_overrun", 32'(ovr_cnt - ovr_base), 32'd0);
    key_req = '0;
    cyc(2);

    // Key 7 re-rises while pending: one overrun, one result
    ovr_base = ovr_cnt;
    exp_q.push_back(4'd7);
    key_req[7] = 1'b1; cyc(1);
    key_req[7] = 1'b0; cyc(1);
    key_req[7] = 1'b1; cyc(1);
    key_req[7] = 1'b0; cyc(6);
    chk("ovr_pulses", 32'(ovr_cnt - ovr_base), 32'd1);

    // Key 4 re-rises on its CAPTURE edge: set wins, two results, no overrun
    ovr_base = ovr_cnt;
    exp_q.push_back(4'd4); exp_q.push_back(4'd4);
    key_req[4] = 1'b1; cyc(1);
    key_req[4] = 1'b0; cyc(2);
    key_req[4] = 1'b1; cyc(1);
    key_req[4] = 1'b0; cyc(8);
    chk("setwins_no_ovr", 32'(ovr_cnt - ovr_base), 32'd0);
    chk("setwins_empty", 32'(fifo_count), 32'd0);

    // Encoder fault on key 1
    err_base = err_cnt;
    force_en = 1'b1; force_val = 4'd6;
    exp_q.push_back(4'd6);
    key_req[1] = 1'b1;
    cyc(4);
    chk("encerr_pulse", 32'(enc_err), 32'd1);
    chk("encerr_bcd", 32'(out_bcd), 32'd6);
    cyc(1);
    chk("encerr_cleared", 32'(enc_err), 32'd0);
    chk("encerr_count", 32'(err_cnt - err_base), 32'd1);
    force_en = 1'b0; key_req = '0; out_ready = 1'b0;
    cyc(2);

    // Async reset during CAPTURE of key 6 with 3,5 queued
    key_req = 9'b000110100;
    cyc(9);
    chk("prerst_count", 32'(fifo_count), 32'd2);
    chk("prerst_enc", 32'(enc_decimal), 32'h020);
    rstN = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_enc", 32'(enc_decimal), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_bcd", 32'(out_bcd), 32'd0);
    key_req = '0;
    cyc(2);
    rstN = 1'b1;
    cyc(2);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    exp_q.push_back(4'd1);
    out_ready = 1'b1;
    key_req[1] = 1'b1;
    cyc(4);
    chk("postrst_bcd", 32'(out_bcd), 32'd1);
    cyc(3);
    key_req = '0;
    chk("all_results_seen", 32'(exp_q.size()), 32'd0);
    chk("final_empty", 32'(fifo_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_key_arbiter.md
Name: bcd_key_arbiter

Overview:
- Shares a single bcd_encoder (9-bit one-hot decimal_in[9:1] in, 4-bit bcd_out out) between nine independent key requesters.
- Detects rising edges on key request lines and holds them as pending requests.
- Grants pending requests round-robin, drives the winner as a one-hot word into the encoder, and captures the encoder's BCD result.
- Queues results in a small FIFO drained through a valid/ready output port; sits between the stimulus/key source and the downstream BCD consumer.

Parameters:
FIFO_DEPTH, 4, result FIFO entries; power of two, minimum 2.

Ports:
test_clk  input  1  clock, all state on rising edge
rstN  input  1  asynchronous active-low reset
key_req  input  9 [9:1]  level key requests, synchronous to test_clk; any number may be high
enc_decimal  output  9 [9:1]  one-hot word to encoder decimal_in; all-zero when not driving
enc_bcd  input  4  encoder bcd_out
out_bcd  output  4  FIFO head value
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head when out_valid && out_ready
overrun  output  1  one-cycle pulse: rising edge on a key already pending
enc_err  output  1  one-cycle pulse: captured enc_bcd != granted key index
busy  output  1  high in DRIVE or CAPTURE
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is asynchronous on rstN low; release is synchronous. Reset values:
  - state=IDLE, pending=0, key_prev=0, rr_ptr=1.
  - FIFO empty, fifo_count=0.
  - Outputs: enc_decimal=0, out_valid=0, out_bcd=0, overrun=0, enc_err=0, busy=0.
- Edge detect: key_prev <= key_req every cycle; rise = key_req & ~key_prev.
  - On rise[k]: pending[k] is set at that edge.
  - If pending[k] is already set (and not being cleared that cycle): the event is dropped and overrun pulses for one cycle.
- Arbiter: round-robin search starting at rr_ptr, ascending, wrapping 9->1.
  - After a grant of key g: rr_ptr <= g+1, with 9 wrapping to 1.
- FSM, three states:
  - IDLE: if pending != 0 and fifo_count < FIFO_DEPTH, then grant g, register enc_decimal = one-hot(g), go to DRIVE. Otherwise stay, with enc_decimal=0.
  - DRIVE: hold enc_decimal; go to CAPTURE (one settle cycle).
  - CAPTURE: hold enc_decimal. At the exiting edge:
    - push enc_bcd into FIFO;
    - clear pending[g];
    - enc_err pulses if enc_bcd != g (4-bit compare);
    - enc_decimal <= 0; go to IDLE.
- Latency: from the edge that sets pending to out_valid high is 3 edges (grant, DRIVE->CAPTURE, push); back-to-back grants every 3 cycles.
- Simultaneous rise[g] and clear of pending[g] in CAPTURE: set wins, pending[g] stays 1, no overrun.
- FIFO full: no grant is issued; pending bits are held. Because a grant requires a free slot and only one item is in flight, a push never hits a full FIFO.
- Push and pop in the same cycle: fifo_count unchanged. Pop on empty is ignored. out_bcd holds its last value when empty.
- Pointer wrap: FIFO read/write pointers wrap modulo FIFO_DEPTH.
- Reset mid-operation (DRIVE or CAPTURE): the in-flight request is lost, the FIFO is flushed, and all outputs return to reset values immediately.
- Invariants for verification:
  - enc_decimal is $onehot0 at all times.
  - busy == (state != IDLE).

Test Plan:
- Single key: key_req[3] rises and is held → pending set at edge E0; enc_decimal=9'b000000100 after E1; out_valid=1, out_bcd=4'd3 after E3; out_ready=1 pops it, fifo_count back to 0.
- Simultaneous keys: key_req[2],[5],[9] rise together with rr_ptr=1 → grant order 2,5,9; FIFO holds 2,5,9 in that order; rr_ptr ends at 1 (9 wraps).
- FIFO full backpressure: out_ready=0, six keys pressed, FIFO_DEPTH=4 → exactly 4 entries, then IDLE with pending nonzero and no grants. Raising out_ready drains all 6 in round-robin order, with no overrun.
- Overrun and set-wins:
  - Key 7 pulses twice while still pending → one overrun pulse, one result of 7.
  - Key 4 re-rises in its CAPTURE cycle → two results of 4, no overrun.
- Encoder fault: bench forces enc_bcd=4'd6 during a grant of key 1 → enc_err pulses exactly one cycle at the CAPTURE edge; value 6 is queued.
- Async reset: rstN low during CAPTURE with FIFO holding 2 entries → outputs zero immediately; after release, out_valid=0 and the first new press of key 1 yields 1.
